// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: fetches instructions, holds A/D/PC, drives the
// external combinational ALU and sequences data-memory reads and writes.
module hack_cpu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] instr_addr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        retire
);

    // Handshakes: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // mem_req/mem_we/mem_addr/mem_wdata are held until the edge of the cycle with mem_ack high.
    typedef enum logic [1:0] {FETCH, RDM, EXEC, WRM} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [15:0] mreg;
    logic [14:0] pc_inc;
    logic        ir_is_c;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic        jump_taken;
    logic        fetch_reads_m;

    assign ir_is_c       = ir[15];
    assign dest_a        = ir[5];
    assign dest_d        = ir[4];
    assign dest_m        = ir[3];
    assign pc_inc        = instr_addr + 15'd1;
    assign fetch_reads_m = instr[15] & instr[12];

    assign jump_taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

    assign alu_x  = d_reg;
    assign alu_y  = ir[12] ? mreg : a_reg;
    assign alu_zx = ir[11];
    assign alu_nx = ir[10];
    assign alu_zy = ir[9];
    assign alu_ny = ir[8];
    assign alu_f  = ir[7];
    assign alu_no = ir[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        retire      = 1'b0;
        case (state)
            FETCH: begin
                // Gated by rst_n so no transfer is advertised while reset is held.
                instr_ready = rst_n;
                if (instr_valid) begin
                    state_next = fetch_reads_m ? RDM : EXEC;
                end
            end
            RDM: begin
                if (mem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (ir_is_c && dest_m) begin
                    state_next = WRM;
                end else begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            WRM: begin
                if (mem_ack) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            d_reg      <= '0;
            instr_addr <= '0;
            ir         <= '0;
            mreg       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir <= instr;
                        if (fetch_reads_m) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= a_reg[14:0];
                        end
                    end
                end
                RDM: begin
                    if (mem_ack) begin
                        mreg    <= mem_rdata;
                        mem_req <= 1'b0;
                    end
                end
                EXEC: begin
                    if (!ir_is_c) begin
                        a_reg      <= {1'b0, ir[14:0]};
                        instr_addr <= pc_inc;
                    end else begin
                        if (dest_a) begin
                            a_reg <= alu_out;
                        end
                        if (dest_d) begin
                            d_reg <= alu_out;
                        end
                        // Jump target and store address both use A as it was before this edge.
                        instr_addr <= jump_taken ? a_reg[14:0] : pc_inc;
                        if (dest_m) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= a_reg[14:0];
                            mem_wdata <= alu_out;
                        end
                    end
                end
                WRM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: the bench plays ALU, instruction source and
// data memory, and predicts each instruction's architectural effect and latency.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] instr_addr;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        retire;

    int          tests = 0;
    int          fails = 0;
    int          total_retires = 0;

    logic [15:0] dmem [0:32767];
    logic [30:0] exp_q [$];
    logic [15:0] m_a = '0;
    logic [15:0] m_d = '0;
    logic [14:0] m_pc = '0;

    always #5 clk = ~clk;

    hack_cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
        .alu_ng(alu_ng), .a_reg(a_reg), .d_reg(d_reg), .retire(retire)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0000 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? xx + yy : xx & yy;
        return c[0] ? ~o : o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    // Execute one instruction through the DUT with 'waits' wait states per memory access.
    task automatic run_instr(input logic [15:0] ins, input int waits);
        logic [15:0] e_a, e_d, y, out;
        logic [14:0] e_pc;
        logic [5:0]  ctl;
        bit          is_c, rd_m, wr_m, taken, addr_ok, data_ok, ret_ack;
        int          e_lat, cyc, retires, ret_cyc, req_cnt, rd_cyc, wr_cyc, guard;
        is_c  = ins[15];
        rd_m  = is_c && ins[12];
        wr_m  = is_c && ins[3];
        e_a   = m_a;
        e_d   = m_d;
        e_pc  = m_pc + 15'd1;
        out   = '0;
        taken = 1'b0;
        if (!is_c) begin
            e_a = {1'b0, ins[14:0]};
        end else begin
            y   = ins[12] ? dmem[m_a[14:0]] : m_a;
            out = hack_alu(m_d, y, ins[11:6]);
            if (ins[5]) e_a = out;
            if (ins[4]) e_d = out;
            taken = (ins[2] && out[15]) || (ins[1] && out == 16'h0) ||
                    (ins[0] && !out[15] && out != 16'h0);
            if (taken) e_pc = m_a[14:0];
            if (wr_m) exp_q.push_back({m_a[14:0], out});
        end
        e_lat = 2 + (int'(rd_m) + int'(wr_m)) * (waits + 1);

        guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        instr       = ins;
        instr_valid = 1'b1;
        mem_ack     = 1'b0;
        cyc = 1; retires = 0; ret_cyc = 0; req_cnt = 0; rd_cyc = 0; wr_cyc = 0;
        addr_ok = 1'b1; data_ok = 1'b1; ret_ack = 1'b0; ctl = '0;
        while (retires == 0 && cyc < e_lat + 20) begin
            @(negedge clk);
            cyc++;
            // Junk on the instruction port and stray acks must be ignored by the DUT.
            instr       = 16'($urandom);
            instr_valid = 1'($urandom_range(0, 1));
            mem_ack     = 1'b0;
            mem_rdata   = 16'($urandom);
            if (mem_req === 1'b1) begin
                req_cnt++;
                if (mem_addr !== m_a[14:0]) addr_ok = 1'b0;
                if (mem_we === 1'b1) begin
                    wr_cyc++;
                    if (exp_q.size() == 0 || mem_wdata !== exp_q[0][15:0]) data_ok = 1'b0;
                end else begin
                    rd_cyc++;
                end
                if (req_cnt == waits + 1) begin
                    mem_ack = 1'b1;
                    req_cnt = 0;
                    if (mem_we === 1'b1) begin
                        dmem[mem_addr] = mem_wdata;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end else begin
                        mem_rdata = dmem[mem_addr];
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
            end
            #1;
            if (retire === 1'b1) begin
                retires++;
                ret_cyc = cyc;
                ret_ack = mem_ack;
                ctl     = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
            end
        end
        total_retires += retires;
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        #1;

        tests++;
        if (retires != 1) begin
            fails++;
            $display("FAIL retire_seen ins=%h: got %0d pulses, expected 1", ins, retires);
        end
        tests++;
        if (ret_cyc != e_lat) begin
            fails++;
            $display("FAIL latency ins=%h: got %0d cycles, expected %0d", ins, ret_cyc, e_lat);
        end
        tests++;
        if (retire !== 1'b0) begin
            fails++;
            $display("FAIL retire_width ins=%h: got %b after retire, expected 0", ins, retire);
        end
        tests++;
        if (a_reg !== e_a) begin
            fails++;
            $display("FAIL a_reg ins=%h: got %h, expected %h", ins, a_reg, e_a);
        end
        tests++;
        if (d_reg !== e_d) begin
            fails++;
            $display("FAIL d_reg ins=%h: got %h, expected %h", ins, d_reg, e_d);
        end
        tests++;
        if (instr_addr !== e_pc) begin
            fails++;
            $display("FAIL pc ins=%h: got %h, expected %h", ins, instr_addr, e_pc);
        end
        tests++;
        if (rd_cyc != int'(rd_m) * (waits + 1) || wr_cyc != int'(wr_m) * (waits + 1)) begin
            fails++;
            $display("FAIL req_cycles ins=%h: got rd=%0d wr=%0d, expected rd=%0d wr=%0d", ins,
                     rd_cyc, wr_cyc, int'(rd_m) * (waits + 1), int'(wr_m) * (waits + 1));
        end
        tests++;
        if (!addr_ok || !data_ok) begin
            fails++;
            $display("FAIL mem_bus ins=%h: got addr_ok=%b data_ok=%b, expected both 1", ins,
                     addr_ok, data_ok);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL write_done ins=%h: got %0d pending writes, expected 0", ins,
                     exp_q.size());
            exp_q.delete();
        end
        if (is_c) begin
            tests++;
            if (ctl !== ins[11:6]) begin
                fails++;
                $display("FAIL alu_ctl ins=%h: got %b, expected %b", ins, ctl, ins[11:6]);
            end
        end
        if (wr_m) begin
            tests++;
            if (!ret_ack) begin
                fails++;
                $display("FAIL retire_on_ack ins=%h: got ack=%b at retire, expected 1", ins, ret_ack);
            end
        end
        m_a  = e_a;
        m_d  = e_d;
        m_pc = e_pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (instr_ready !== 1'b0 || mem_req !== 1'b0 || retire !== 1'b0 || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctl: got ready=%b req=%b retire=%b we=%b, expected all 0",
                         instr_ready, mem_req, retire, mem_we);
            end
            tests++;
            if (mem_addr !== 15'h0 || mem_wdata !== 16'h0) begin
                fails++;
                $display("FAIL reset_bus: got addr=%h wdata=%h, expected 0", mem_addr, mem_wdata);
            end
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (instr_ready !== 1'b1 || instr_addr !== 15'h0 || a_reg !== 16'h0 || d_reg !== 16'h0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b pc=%h a=%h d=%h, expected 1/0/0/0",
                     instr_ready, instr_addr, a_reg, d_reg);
        end
        m_a = '0; m_d = '0; m_pc = '0;
    endtask

    task automatic test_a_then_d();
        int r0;
        r0 = total_retires;
        run_instr(16'h0005, 0);
        run_instr(16'hEC10, 0);
        tests++;
        if (a_reg !== 16'd5 || d_reg !== 16'd5 || instr_addr !== 15'd2 || total_retires - r0 != 2) begin
            fails++;
            $display("FAIL a_then_d: got a=%h d=%h pc=%h retires=%0d, expected 5/5/2/2",
                     a_reg, d_reg, instr_addr, total_retires - r0);
        end
    endtask

    task automatic test_read_wait();
        dmem[100] = 16'h1234;
        run_instr(16'd100, 0);
        run_instr(16'hFC10, 2);
        tests++;
        if (d_reg !== 16'h1234) begin
            fails++;
            $display("FAIL read_wait: got d=%h, expected 1234", d_reg);
        end
    endtask

    task automatic test_write();
        run_instr(16'd7, 0);
        run_instr(16'hEC10, 0);
        run_instr(16'd200, 0);
        run_instr(16'hE7C8, 0);
        tests++;
        if (dmem[200] !== 16'd8 || a_reg !== 16'd200 || d_reg !== 16'd7) begin
            fails++;
            $display("FAIL write: got mem=%h a=%h d=%h, expected 8/c8/7", dmem[200], a_reg, d_reg);
        end
    endtask

    task automatic test_jumps();
        logic [14:0] pc0;
        run_instr(16'hEA90, 0);
        run_instr(16'd42, 0);
        run_instr(16'hE302, 0);
        tests++;
        if (instr_addr !== 15'd42) begin
            fails++;
            $display("FAIL jeq_taken: got pc=%h, expected 2a", instr_addr);
        end
        pc0 = instr_addr;
        run_instr(16'hE301, 0);
        tests++;
        if (instr_addr !== pc0 + 15'd1) begin
            fails++;
            $display("FAIL jgt_not_taken: got pc=%h, expected %h", instr_addr, pc0 + 15'd1);
        end
        run_instr(16'hEE90, 0);
        run_instr(16'hE304, 0);
        tests++;
        if (instr_addr !== 15'd42) begin
            fails++;
            $display("FAIL jlt_taken: got pc=%h, expected 2a", instr_addr);
        end
        run_instr(16'h7FFF, 0);
        run_instr(16'hEA90, 0);
        run_instr(16'hE302, 0);
        run_instr(16'hEA90, 1);
        tests++;
        if (instr_addr !== 15'd0) begin
            fails++;
            $display("FAIL pc_wrap: got pc=%h, expected 0", instr_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 150; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 0) ins[15] = 1'b0;
            run_instr(ins, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid_write();
        int  guard;
        bit  seen;
        run_instr(16'd7, 0);
        run_instr(16'hEC10, 0);
        run_instr(16'd200, 0);
        dmem[200] = 16'hBEEF;
        instr       = 16'hE7C8;
        instr_valid = 1'b1;
        guard = 0;
        seen  = 1'b0;
        while (!seen && guard < 10) begin
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ack     = 1'b0;
            #1;
            guard++;
            if (mem_req === 1'b1 && mem_we === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL mid_write_setup: got no write request, expected one");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || retire !== 1'b0) begin
            fails++;
            $display("FAIL mid_write_drop: got req=%b retire=%b, expected 0/0", mem_req, retire);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (instr_ready !== 1'b1 || instr_addr !== 15'h0 || a_reg !== 16'h0 || d_reg !== 16'h0) begin
            fails++;
            $display("FAIL mid_write_release: got ready=%b pc=%h a=%h d=%h, expected 1/0/0/0",
                     instr_ready, instr_addr, a_reg, d_reg);
        end
        tests++;
        if (dmem[200] !== 16'hBEEF) begin
            fails++;
            $display("FAIL mid_write_mem: got %h, expected beef", dmem[200]);
        end
        m_a = '0; m_d = '0; m_pc = '0;
        run_instr(16'hEC10, 0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) dmem[i] = 16'($urandom);
        test_reset();
        test_a_then_d();
        test_read_wait();
        test_write();
        test_jumps();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
